psk_mode_sequencer: RTL and testbench

- Run-time configuration sequencer for the Tx/Rx PSK datapath.
- Owns the datapath configuration registers: MODE_CTRL, TX_PHASE_CONFIG, FEEDBACK_SHIFT and GARDNER_SHIFT.
- Applies a requested change glitch-free: drain the current Tx frame, hold the Rx loops (Costas/Gardner) in reset, update the registers, then release and wait for Rx signal detect.
- Sits between the host/control logic and the Tx_/Rx_ hierarchies, in the 1.024 MHz symbol-rate domain.

---
 rtl/psk_mode_sequencer_if.sv | 29 ++
 rtl/psk_mode_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_psk_mode_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/psk_mode_sequencer_if.sv
// Host-side configuration request channel for psk_mode_sequencer.
//   cfg_req            : level request, held by the host until cfg_ack
//   cfg_mode           : requested mode, one-hot (0001 BPSK, 0010 QPSK, 0100 MIX)
//   cfg_phase          : requested TX_PHASE_CONFIG
//   cfg_feedback_shift : requested FEEDBACK_SHIFT
//   cfg_gardner_shift  : requested GARDNER_SHIFT
//   cfg_ack            : one-cycle completion/reject pulse
//   cfg_err            : qualifies cfg_ack; set on reject or lock timeout
interface psk_mode_sequencer_if;
  logic        cfg_req;
  logic [3:0]  cfg_mode;
  logic [15:0] cfg_phase;
  logic [3:0]  cfg_feedback_shift;
  logic [3:0]  cfg_gardner_shift;
  logic        cfg_ack;
  logic        cfg_err;

  // Host side issues requests and receives the acknowledge.
  modport master (
    output cfg_req, cfg_mode, cfg_phase, cfg_feedback_shift, cfg_gardner_shift,
    input  cfg_ack, cfg_err
  );

  // Sequencer side consumes requests and produces the acknowledge.
  modport slave (
    input  cfg_req, cfg_mode, cfg_phase, cfg_feedback_shift, cfg_gardner_shift,
    output cfg_ack, cfg_err
  );
endinterface

// File: rtl/psk_mode_sequencer.sv
// Run-time configuration sequencer for the Tx/Rx PSK datapath (1.024 MHz domain).
// Owns MODE_CTRL / TX_PHASE_CONFIG / FEEDBACK_SHIFT / GARDNER_SHIFT and applies a
// change glitch-free: drain the Tx frame, hold the Rx loops in reset, update the
// registers, release the loops and wait for Rx lock.
// Ports:
//   clk_1M024, rst_n_1M024 : symbol-rate clock, async active-low reset
//   cfg                    : request channel (psk_mode_sequencer_if.slave)
//   tx_tvalid, tx_tlast    : monitored Tx stream handshake
//   rx_locked              : Rx signal-detect / lock
//   MODE_CTRL, TX_PHASE_CONFIG, FEEDBACK_SHIFT, GARDNER_SHIFT : datapath configuration
//   tx_enable              : gates the Tx data source
//   rx_loop_rst            : active-high synchronous reset to the Costas/Gardner loops
//   busy                   : high in every state except RUN
//   state                  : current state encoding (debug)
module psk_mode_sequencer #(
  parameter int unsigned FLUSH_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic                 clk_1M024,
  input  logic                 rst_n_1M024,
  psk_mode_sequencer_if.slave  cfg,
  input  logic                 tx_tvalid,
  input  logic                 tx_tlast,
  input  logic                 rx_locked,
  output logic [3:0]           MODE_CTRL,
  output logic [15:0]          TX_PHASE_CONFIG,
  output logic [3:0]           FEEDBACK_SHIFT,
  output logic [3:0]           GARDNER_SHIFT,
  output logic                 tx_enable,
  output logic                 rx_loop_rst,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = 65535;

  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [3:0]  MODE_BPSK = 4'b0001;
  localparam logic [3:0]  MODE_QPSK = 4'b0010;
  localparam logic [3:0]  MODE_MIX  = 4'b0100;
  localparam logic [15:0] PHASE_RST = 16'd8224;
  localparam logic [3:0]  FB_RST    = 4'd0;
  localparam logic [3:0]  GD_RST    = 4'd3;

  // Every timing parameter must fit the 16-bit counter and be non-zero.
  if (FLUSH_CYCLES  < 1 || FLUSH_CYCLES  > CNT_MAX ||
      SETTLE_CYCLES < 1 || SETTLE_CYCLES > CNT_MAX ||
      DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > CNT_MAX ||
      LOCK_TIMEOUT  < 1 || LOCK_TIMEOUT  > CNT_MAX) begin : g_bad_param
    $error("psk_mode_sequencer: timing parameters must be in 1..65535");
  end

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_DRAIN    = 3'd1,
    S_FLUSH    = 3'd2,
    S_APPLY    = 3'd3,
    S_SETTLE   = 3'd4,
    S_LOCKWAIT = 3'd5
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [3:0]       sh_mode;
  logic [15:0]      sh_phase;
  logic [3:0]       sh_fb;
  logic [3:0]       sh_gd;

  logic             mode_ok_c;
  logic             drain_done_c;
  logic             lock_done_c;

  // Only the three legal one-hot modes are accepted.
  assign mode_ok_c = (cfg.cfg_mode == MODE_BPSK) ||
                     (cfg.cfg_mode == MODE_QPSK) ||
                     (cfg.cfg_mode == MODE_MIX);

  // Frame boundary, idle stream, or drain timeout ends DRAIN.
  assign drain_done_c = (tx_tvalid & tx_tlast) | ~tx_tvalid | (cnt == DRAIN_LAST);

  assign lock_done_c  = rx_locked | (cnt == LOCK_LAST);

  assign state = st;

  // Sequencer state, counter, shadow and output registers.
  always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
    if (!rst_n_1M024) begin
      st              <= S_FLUSH;
      cnt             <= '0;
      pending         <= 1'b0;
      sh_mode         <= MODE_BPSK;
      sh_phase        <= PHASE_RST;
      sh_fb           <= FB_RST;
      sh_gd           <= GD_RST;
      MODE_CTRL       <= MODE_BPSK;
      TX_PHASE_CONFIG <= PHASE_RST;
      FEEDBACK_SHIFT  <= FB_RST;
      GARDNER_SHIFT   <= GD_RST;
      tx_enable       <= 1'b0;
      rx_loop_rst     <= 1'b1;
      cfg.cfg_ack     <= 1'b0;
      cfg.cfg_err     <= 1'b0;
      busy            <= 1'b1;
    end else begin
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
      cnt         <= cnt + CNT_W'(1);

      case (st)
        S_RUN: begin
          cnt <= '0;
          // The ack cycle itself is not a sampling point, so a held request
          // is only taken as a new one in the following cycle.
          if (cfg.cfg_req && !cfg.cfg_ack) begin
            if (!mode_ok_c) begin
              cfg.cfg_ack <= 1'b1;
              cfg.cfg_err <= 1'b1;
            end else begin
              sh_mode  <= cfg.cfg_mode;
              sh_phase <= cfg.cfg_phase;
              sh_fb    <= cfg.cfg_feedback_shift;
              sh_gd    <= cfg.cfg_gardner_shift;
              pending  <= 1'b1;
              st       <= S_DRAIN;
              busy     <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (drain_done_c) begin
            st          <= S_FLUSH;
            cnt         <= '0;
            tx_enable   <= 1'b0;
            rx_loop_rst <= 1'b1;
          end
        end

        S_FLUSH: begin
          // New configuration becomes visible on entry to APPLY, loops still held.
          if (cnt == FLUSH_LAST) begin
            st  <= S_APPLY;
            cnt <= '0;
            if (pending) begin
              MODE_CTRL       <= sh_mode;
              TX_PHASE_CONFIG <= sh_phase;
              FEEDBACK_SHIFT  <= sh_fb;
              GARDNER_SHIFT   <= sh_gd;
            end
          end
        end

        S_APPLY: begin
          st          <= S_SETTLE;
          cnt         <= '0;
          rx_loop_rst <= 1'b0;
          tx_enable   <= 1'b1;
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            st  <= S_LOCKWAIT;
            cnt <= '0;
          end
        end

        S_LOCKWAIT: begin
          // Lock wins over a coincident timeout.
          if (lock_done_c) begin
            st          <= S_RUN;
            cnt         <= '0;
            busy        <= 1'b0;
            cfg.cfg_ack <= pending;
            cfg.cfg_err <= pending & ~rx_locked;
            pending     <= 1'b0;
          end
        end

        default: begin
          st          <= S_FLUSH;
          cnt         <= '0;
          pending     <= 1'b0;
          tx_enable   <= 1'b0;
          rx_loop_rst <= 1'b1;
          busy        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psk_mode_sequencer.sv
// Directed self-checking bench for psk_mode_sequencer with an ack scoreboard.
module tb_psk_mode_sequencer;

  logic        clk_1M024 = 1'b0;
  logic        rst_n_1M024;
  logic        tx_tvalid, tx_tlast, rx_locked;
  logic [3:0]  MODE_CTRL, FEEDBACK_SHIFT, GARDNER_SHIFT;
  logic [15:0] TX_PHASE_CONFIG;
  logic        tx_enable, rx_loop_rst, busy;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [3:0]  mode;
    logic [15:0] phase;
    logic [3:0]  fb;
    logic [3:0]  gd;
    logic [2:0]  st;
    logic        bsy;
  } exp_t;

  exp_t exp_q[$];

  psk_mode_sequencer_if cfg_if();

  psk_mode_sequencer dut (
    .clk_1M024       (clk_1M024),
    .rst_n_1M024     (rst_n_1M024),
    .cfg             (cfg_if),
    .tx_tvalid       (tx_tvalid),
    .tx_tlast        (tx_tlast),
    .rx_locked       (rx_locked),
    .MODE_CTRL       (MODE_CTRL),
    .TX_PHASE_CONFIG (TX_PHASE_CONFIG),
    .FEEDBACK_SHIFT  (FEEDBACK_SHIFT),
    .GARDNER_SHIFT   (GARDNER_SHIFT),
    .tx_enable       (tx_enable),
    .rx_loop_rst     (rx_loop_rst),
    .busy            (busy),
    .state           (state)
  );

  always #5 clk_1M024 = ~clk_1M024;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest expected response.
  always @(negedge clk_1M024) begin
    if (rst_n_1M024 === 1'b1 && cfg_if.cfg_ack === 1'b1) begin
      exp_t act;
      exp_t req;
      act = '{err: cfg_if.cfg_err, mode: MODE_CTRL, phase: TX_PHASE_CONFIG,
              fb: FEEDBACK_SHIFT, gd: GARDNER_SHIFT, st: state, bsy: busy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack err=%0d mode=%b, expected no ack",
                 act.err, act.mode);
      end else begin
        req = exp_q.pop_front();
        if (act !== req) begin
          errors++;
          $display("FAIL ack_response: got err=%0d mode=%b phase=%0d fb=%0d gd=%0d state=%0d busy=%0d, expected err=%0d mode=%b phase=%0d fb=%0d gd=%0d state=%0d busy=%0d",
                   act.err, act.mode, act.phase, act.fb, act.gd, act.st, act.bsy,
                   req.err, req.mode, req.phase, req.fb, req.gd, req.st, req.bsy);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_1M024);
    @(negedge clk_1M024);
  endtask

  function automatic logic [1:0] exp_ctl(input logic [2:0] s);
    // {tx_enable, rx_loop_rst} expected in each state
    case (s)
      3'd2, 3'd3: exp_ctl = 2'b01;
      default:    exp_ctl = 2'b10;
    endcase
  endfunction

  // Waits for state s, then counts its consecutive cycles; optionally raises
  // tx_tlast in the tlast_at-th cycle. bad counts cycles with wrong tx_enable/rx_loop_rst.
  task automatic count_state(input logic [2:0] s, input int tlast_at, output int n, output int bad);
    int g;
    g = 0; n = 0; bad = 0;
    while (state !== s && g < 3000) begin step(); g++; end
    while (state === s && g < 3000) begin
      n++;
      if (n == tlast_at) tx_tlast = 1'b1;
      if ({tx_enable, rx_loop_rst} !== exp_ctl(s)) bad++;
      step(); g++;
    end
  endtask

  task automatic count_to_run(output int n);
    n = 0;
    do begin step(); n++; end while (state !== 3'd0 && n < 3000);
  endtask

  task automatic wait_ack(input string name);
    int g;
    g = 0;
    while (cfg_if.cfg_ack !== 1'b1 && g < 3000) begin step(); g++; end
    if (g >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no cfg_ack, expected cfg_ack within 3000 cycles", name);
    end
    cfg_if.cfg_req = 1'b0;
  endtask

  task automatic issue(input logic [3:0] m, input logic [15:0] p, input logic [3:0] fb, input logic [3:0] gd);
    step();
    cfg_if.cfg_mode           = m;
    cfg_if.cfg_phase          = p;
    cfg_if.cfg_feedback_shift = fb;
    cfg_if.cfg_gardner_shift  = gd;
    cfg_if.cfg_req            = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, g;

    rst_n_1M024 = 1'b0;
    tx_tvalid = 1'b0; tx_tlast = 1'b0; rx_locked = 1'b1;
    cfg_if.cfg_req = 1'b0; cfg_if.cfg_mode = 4'd0; cfg_if.cfg_phase = 16'd0;
    cfg_if.cfg_feedback_shift = 4'd0; cfg_if.cfg_gardner_shift = 4'd0;

    // Reset values
    repeat (3) @(negedge clk_1M024);
    chk("rst_mode",  32'(MODE_CTRL), 32'd1);
    chk("rst_phase", 32'(TX_PHASE_CONFIG), 32'd8224);
    chk("rst_fb",    32'(FEEDBACK_SHIFT), 32'd0);
    chk("rst_gd",    32'(GARDNER_SHIFT), 32'd3);
    chk("rst_ctl",   32'({tx_enable, rx_loop_rst, cfg_if.cfg_ack, cfg_if.cfg_err, busy}), 32'b01001);
    chk("rst_state", 32'(state), 32'd2);

    // Start-up sequence reaches RUN at cycle 82, no ack
    rst_n_1M024 = 1'b1;
    count_to_run(n);
    chk("startup_cycles", 32'(n), 32'd82);
    chk("startup_busy", 32'(busy), 32'd0);

    // QPSK request while a frame is in flight; tlast in the 10th drain cycle
    tx_tvalid = 1'b1;
    issue(4'b0010, 16'd8256, 4'd1, 4'd2);
    exp_q.push_back('{1'b0, 4'b0010, 16'd8256, 4'd1, 4'd2, 3'd0, 1'b0});
    count_state(3'd1, 10, n, bad);
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
    chk("qpsk_drain_cycles", 32'(n), 32'd10);
    chk("qpsk_drain_ctl", 32'(bad), 32'd0);
    count_state(3'd2, 0, n, bad);
    chk("qpsk_flush_cycles", 32'(n), 32'd16);
    chk("qpsk_flush_ctl", 32'(bad), 32'd0);
    chk("qpsk_apply_state", 32'(state), 32'd3);
    chk("qpsk_apply_mode", 32'(MODE_CTRL), 32'b0010);
    chk("qpsk_apply_phase", 32'(TX_PHASE_CONFIG), 32'd8256);
    chk("qpsk_apply_rst", 32'(rx_loop_rst), 32'd1);
    count_state(3'd4, 0, n, bad);
    chk("qpsk_settle_cycles", 32'(n), 32'd64);
    chk("qpsk_settle_ctl", 32'(bad), 32'd0);
    wait_ack("qpsk");

    // Illegal mode: immediate reject, RUN and outputs untouched
    issue(4'b0011, 16'd1234, 4'd9, 4'd9);
    exp_q.push_back('{1'b1, 4'b0010, 16'd8256, 4'd1, 4'd2, 3'd0, 1'b0});
    step();
    chk("reject_latency", 32'(cfg_if.cfg_ack), 32'd1);
    wait_ack("reject");
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (state !== 3'd0 || tx_enable !== 1'b1 || MODE_CTRL !== 4'b0010) bad++;
    end
    chk("reject_run_stable", 32'(bad), 32'd0);

    // Frame that never ends: drain timeout after 256 cycles
    tx_tvalid = 1'b1;
    issue(4'b0100, 16'd1000, 4'd5, 4'd6);
    exp_q.push_back('{1'b0, 4'b0100, 16'd1000, 4'd5, 4'd6, 3'd0, 1'b0});
    count_state(3'd1, 0, n, bad);
    tx_tvalid = 1'b0;
    chk("timeout_drain_cycles", 32'(n), 32'd256);
    wait_ack("mix");

    // No lock: ack with error after 1024 LOCKWAIT cycles, new config stays
    rx_locked = 1'b0;
    issue(4'b0001, 16'd500, 4'd7, 4'd1);
    exp_q.push_back('{1'b1, 4'b0001, 16'd500, 4'd7, 4'd1, 3'd0, 1'b0});
    count_state(3'd5, 0, n, bad);
    chk("lock_timeout_cycles", 32'(n), 32'd1024);
    chk("lock_timeout_ctl", 32'(bad), 32'd0);
    wait_ack("nolock");
    rx_locked = 1'b1;

    // Reset in SETTLE of a pending QPSK request; held request re-sampled later
    issue(4'b0010, 16'd8256, 4'd1, 4'd2);
    g = 0;
    while (state !== 3'd4 && g < 3000) begin step(); g++; end
    repeat (5) step();
    chk("pre_reset_mode", 32'(MODE_CTRL), 32'b0010);
    #2 rst_n_1M024 = 1'b0;
    #1;
    chk("async_rst_mode",  32'(MODE_CTRL), 32'd1);
    chk("async_rst_phase", 32'(TX_PHASE_CONFIG), 32'd8224);
    chk("async_rst_shift", 32'({FEEDBACK_SHIFT, GARDNER_SHIFT}), 32'h03);
    chk("async_rst_ctl",   32'({state, busy, tx_enable, rx_loop_rst}), 32'b010101);
    repeat (2) @(negedge clk_1M024);
    exp_q.push_back('{1'b0, 4'b0010, 16'd8256, 4'd1, 4'd2, 3'd0, 1'b0});
    rst_n_1M024 = 1'b1;
    count_to_run(n);
    chk("restart_cycles", 32'(n), 32'd82);
    wait_ack("resample");
    repeat (10) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
